// File: rtl/map_pkg.sv
// map_pkg: write-op encodings and sweep FSM states shared by the map store blocks.
package map_pkg;
  localparam logic [1:0] OP_WORD = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
endpackage

// File: rtl/map_bit_alu.sv
// map_bit_alu: combinational row update for word write and single-bit set/clear/toggle.
module map_bit_alu
  import map_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] old_row,
  input  logic [1:0]       wr_op,
  input  logic [CW-1:0]    wr_col,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] new_row
);
  logic [WIDTH-1:0] mask;
  always_comb begin
    mask = WIDTH'(1) << wr_col;
    new_row = wr_op == OP_WORD ? wr_data :
              wr_op == OP_SET  ? old_row | mask :
              wr_op == OP_CLR  ? old_row & ~mask : old_row ^ mask;
  end
endmodule

// File: rtl/map_store.sv
// map_store: writable WIDTH x DEPTH play-field bitmap with registered row/bit reads and a clear sweep.
module map_store
  import map_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_bits,
  input  logic [AW-1:0]    q_row,
  input  logic [CW-1:0]    q_col,
  output logic             q_hit,
  input  logic             wr_en,
  input  logic [1:0]       wr_op,
  input  logic [AW-1:0]    wr_addr,
  input  logic [CW-1:0]    wr_col,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done
);
  state_t state, state_nx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] cnt;
  logic [WIDTH-1:0] old_row, new_row;
  logic clr_start, last, wr_row_ok, wr_ok, rd_ok, q_ok;

  map_bit_alu #(.WIDTH(WIDTH)) u_alu (
    .old_row(old_row), .wr_op(wr_op), .wr_col(wr_col), .wr_data(wr_data), .new_row(new_row)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_IDLE;
    else state <= state_nx;

  // A clear request in IDLE takes priority over a same-cycle write.
  always_comb begin
    clr_start = state == ST_IDLE && clr_req;
    last = state == ST_CLEAR && 32'(cnt) == DEPTH - 1;
    wr_row_ok = 32'(wr_addr) < DEPTH;
    wr_ok = wr_en && state == ST_IDLE && !clr_req && wr_row_ok &&
            (wr_op == OP_WORD || 32'(wr_col) < WIDTH);
    rd_ok = 32'(rd_addr) < DEPTH;
    q_ok = 32'(q_row) < DEPTH && 32'(q_col) < WIDTH;
    old_row = wr_row_ok ? mem[wr_addr] : '0;
    state_nx = clr_start ? ST_CLEAR : last ? ST_IDLE : state;
  end

  assign busy = state == ST_CLEAR;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_bits <= '0;
      q_hit <= 1'b0;
      cnt <= '0;
      clr_done <= 1'b0;
    end else begin
      rd_bits <= rd_ok ? mem[rd_addr] : '0;
      q_hit <= q_ok && mem[q_row][q_col];
      clr_done <= last;
      cnt <= clr_start ? '0 : busy ? cnt + 1'b1 : cnt;
      if (busy) mem[cnt] <= '0;
      else if (wr_ok) mem[wr_addr] <= new_row;
    end
endmodule

// File: tb/tb_map_store.sv
// tb_map_store: scoreboard bench for map_store (DEPTH=32 main instance, DEPTH=20 range instance).
module tb_map_store;
  import map_pkg::*;
  logic clk = 0, reset = 1;
  logic [4:0] rd_addr = 0, q_row = 0, q_col = 0, wr_addr = 0, wr_col = 0;
  logic [31:0] wr_data = 0;
  logic [1:0] wr_op = 0;
  logic wr_en = 0, clr_req = 0;
  logic [31:0] rd_bits;
  logic q_hit, busy, clr_done;
  logic [4:0] s_rd_addr = 0, s_q_row = 0, s_q_col = 0, s_wr_addr = 0, s_wr_col = 0;
  logic [31:0] s_wr_data = 0;
  logic [1:0] s_wr_op = 0;
  logic s_wr_en = 0, s_clr_req = 0;
  logic [31:0] s_rd_bits;
  logic s_q_hit, s_busy, s_clr_done;
  int checks = 0, failures = 0;
  logic [31:0] m [32];
  logic [31:0] rq [$];
  logic hq [$];
  logic mbusy = 0, mdone = 0;
  int mcnt = 0;
  logic [31:0] er;
  logic eh;

  map_store dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_bits(rd_bits), .q_row(q_row), .q_col(q_col),
    .q_hit(q_hit), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr), .wr_col(wr_col),
    .wr_data(wr_data), .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  map_store #(.WIDTH(32), .DEPTH(20)) dut20 (
    .clk(clk), .reset(reset), .rd_addr(s_rd_addr), .rd_bits(s_rd_bits), .q_row(s_q_row),
    .q_col(s_q_col), .q_hit(s_q_hit), .wr_en(s_wr_en), .wr_op(s_wr_op), .wr_addr(s_wr_addr),
    .wr_col(s_wr_col), .wr_data(s_wr_data), .clr_req(s_clr_req), .busy(s_busy),
    .clr_done(s_clr_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [31:0] f(logic [31:0] o, logic [1:0] op, int c, logic [31:0] d);
    case (op)
      2'b00: return d;
      2'b01: return o | (32'h1 << c);
      2'b10: return o & ~(32'h1 << c);
      default: return o ^ (32'h1 << c);
    endcase
  endfunction

  // Pushes read expectations from the pre-edge model, advances the model, then one clock.
  task automatic tick();
    rq.push_back(m[rd_addr]);
    hq.push_back(m[q_row][q_col]);
    if (mbusy) begin
      m[mcnt] = 0;
      mdone = mcnt == 31;
      mbusy = mcnt != 31;
      mcnt++;
    end else begin
      mdone = 0;
      if (clr_req) begin
        mbusy = 1;
        mcnt = 0;
      end else if (wr_en) m[wr_addr] = f(m[wr_addr], wr_op, int'(wr_col), wr_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = 0;
    mbusy = 0; mdone = 0; mcnt = 0;
    rq.delete(); hq.delete();
  endtask

  task automatic test_reset();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 0 || clr_done !== 0) begin failures++; $display("FAIL reset_ctl got busy=%b done=%b exp 0 0", busy, clr_done); end
    checks++; if (rd_bits !== 0 || q_hit !== 0) begin failures++; $display("FAIL reset_out got rd=%h hit=%b exp 0 0", rd_bits, q_hit); end
    reset = 0;
    for (int a = 0; a < 32; a += 31) begin
      rd_addr = 5'(a); q_row = 5'(a); q_col = 5'(a);
      tick();
      er = rq.pop_front(); eh = hq.pop_front();
      checks++; if (rd_bits !== er || rd_bits !== 0) begin failures++; $display("FAIL reset_row%0d got=%h exp=%h", a, rd_bits, er); end
      checks++; if (q_hit !== eh || busy !== 0) begin failures++; $display("FAIL reset_hit%0d got hit=%b busy=%b exp=%b 0", a, q_hit, busy, eh); end
    end
  endtask

  task automatic test_word();
    wr_en = 1; wr_op = OP_WORD; wr_addr = 5; wr_data = 32'hDEADBEEF; rd_addr = 5;
    tick();
    er = rq.pop_front(); eh = hq.pop_front();
    checks++; if (rd_bits !== er) begin failures++; $display("FAIL word_pre got=%h exp=%h", rd_bits, er); end
    wr_en = 0;
    tick();
    er = rq.pop_front(); eh = hq.pop_front();
    checks++; if (rd_bits !== er || rd_bits !== 32'hDEADBEEF) begin failures++; $display("FAIL word_rd got=%h exp=%h", rd_bits, er); end
  endtask

  task automatic test_bitops();
    logic [1:0] ops [3] = '{OP_SET, OP_CLR, OP_TGL};
    logic [4:0] cols [3] = '{5'd0, 5'd1, 5'd31};
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_op = ops[i]; wr_addr = 5; wr_col = cols[i]; wr_data = 32'hFFFF_FFFF;
      rd_addr = 5; q_row = 5; q_col = cols[i];
      tick();
      er = rq.pop_front(); eh = hq.pop_front();
      checks++; if (rd_bits !== er || q_hit !== eh) begin failures++; $display("FAIL bitop%0d got rd=%h hit=%b exp rd=%h hit=%b", i, rd_bits, q_hit, er, eh); end
    end
    wr_en = 0; q_col = 31;
    tick();
    er = rq.pop_front(); eh = hq.pop_front();
    checks++; if (rd_bits !== er || rd_bits !== 32'h5EADBEED) begin failures++; $display("FAIL bitop_row got=%h exp=5eadbeed", rd_bits); end
    checks++; if (q_hit !== eh || q_hit !== 0) begin failures++; $display("FAIL hit_col31 got=%b exp=0", q_hit); end
    q_col = 0;
    tick();
    er = rq.pop_front(); eh = hq.pop_front();
    checks++; if (q_hit !== eh || q_hit !== 1) begin failures++; $display("FAIL hit_col0 got=%b exp=1", q_hit); end
  endtask

  task automatic test_same_cycle();
    wr_en = 1; wr_op = OP_WORD; wr_addr = 3; wr_data = 32'h1; rd_addr = 3;
    tick();
    er = rq.pop_front(); eh = hq.pop_front();
    checks++; if (rd_bits !== er || rd_bits !== 0) begin failures++; $display("FAIL rbw_old got=%h exp=0", rd_bits); end
    wr_en = 0;
    tick();
    er = rq.pop_front(); eh = hq.pop_front();
    checks++; if (rd_bits !== er || rd_bits !== 32'h1) begin failures++; $display("FAIL rbw_new got=%h exp=1", rd_bits); end
  endtask

  task automatic test_clear();
    int nbusy, ndone;
    for (int i = 0; i < 32; i++) begin
      wr_en = 1; wr_op = OP_WORD; wr_addr = 5'(i); wr_data = 32'hFFFF_FFFF; rd_addr = 5'((i + 31) % 32);
      tick();
      er = rq.pop_front(); eh = hq.pop_front();
      checks++; if (rd_bits !== er) begin failures++; $display("FAIL fill%0d got=%h exp=%h", i, rd_bits, er); end
    end
    clr_req = 1; rd_addr = 0;
    tick();
    er = rq.pop_front(); eh = hq.pop_front();
    clr_req = 0;
    checks++; if (busy !== 1 || rd_bits !== er) begin failures++; $display("FAIL clr_start got busy=%b rd=%h exp 1 %h", busy, rd_bits, er); end
    nbusy = int'(busy); ndone = int'(clr_done);
    for (int i = 0; i < 40 && busy; i++) begin
      wr_en = 1; wr_op = OP_WORD; wr_addr = 5'(i % 32); wr_data = 32'h1234; rd_addr = 5'((i * 7) % 32);
      clr_req = i[0];
      tick();
      er = rq.pop_front(); eh = hq.pop_front();
      checks++; if (rd_bits !== er || busy !== mbusy || clr_done !== mdone) begin failures++; $display("FAIL sweep%0d got rd=%h busy=%b done=%b exp rd=%h busy=%b done=%b", i, rd_bits, busy, clr_done, er, mbusy, mdone); end
      nbusy += int'(busy); ndone += int'(clr_done);
    end
    wr_en = 0; clr_req = 0;
    checks++; if (busy !== 0) begin failures++; $display("FAIL sweep_timeout busy still high"); end
    checks++; if (nbusy !== 32) begin failures++; $display("FAIL busy_cycles got=%0d exp=32", nbusy); end
    checks++; if (ndone !== 1 || clr_done !== 1) begin failures++; $display("FAIL done_pulses got=%0d last=%b exp 1 1", ndone, clr_done); end
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      tick();
      er = rq.pop_front(); eh = hq.pop_front();
      checks++; if (rd_bits !== er || rd_bits !== 0 || clr_done !== 0) begin failures++; $display("FAIL cleared%0d got rd=%h done=%b exp 0 0", i, rd_bits, clr_done); end
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    wr_en = 1; wr_op = OP_WORD; wr_addr = 20; wr_data = 32'hAAAA5555;
    tick();
    void'(rq.pop_front()); void'(hq.pop_front());
    wr_en = 0; clr_req = 1;
    tick();
    void'(rq.pop_front()); void'(hq.pop_front());
    clr_req = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      er = rq.pop_front(); eh = hq.pop_front();
      checks++; if (busy !== 1 || rd_bits !== er) begin failures++; $display("FAIL mid%0d got busy=%b rd=%h exp 1 %h", i, busy, rd_bits, er); end
    end
    reset = 1;
    #1;
    checks++; if (busy !== 0 || clr_done !== 0) begin failures++; $display("FAIL abort got busy=%b done=%b exp 0 0", busy, clr_done); end
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    for (int i = 0; i < 34; i++) begin
      rd_addr = 5'((i + 20) % 32);
      tick();
      er = rq.pop_front(); eh = hq.pop_front();
      ndone += int'(clr_done);
      checks++; if (rd_bits !== er || rd_bits !== 0 || busy !== 0) begin failures++; $display("FAIL post_abort%0d got rd=%h busy=%b exp 0 0", i, rd_bits, busy); end
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", ndone); end
  endtask

  task automatic test_range();
    s_wr_en = 1; s_wr_op = OP_WORD; s_wr_addr = 25; s_wr_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    s_wr_addr = 19; s_wr_data = 32'h55;
    @(posedge clk); #1;
    s_wr_en = 0; s_rd_addr = 25; s_q_row = 25; s_q_col = 0;
    @(posedge clk); #1;
    checks++; if (s_rd_bits !== 0 || s_q_hit !== 0) begin failures++; $display("FAIL oob_read got rd=%h hit=%b exp 0 0", s_rd_bits, s_q_hit); end
    s_rd_addr = 9; s_q_row = 9;
    @(posedge clk); #1;
    checks++; if (s_rd_bits !== 0 || s_q_hit !== 0) begin failures++; $display("FAIL oob_alias got rd=%h hit=%b exp 0 0", s_rd_bits, s_q_hit); end
    s_rd_addr = 19; s_q_row = 19;
    @(posedge clk); #1;
    checks++; if (s_rd_bits !== 32'h55 || s_q_hit !== 1) begin failures++; $display("FAIL last_row got rd=%h hit=%b exp 55 1", s_rd_bits, s_q_hit); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_bitops();
    test_same_cycle();
    test_clear();
    test_reset_mid();
    test_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/map_store.md
# map_store

Parametrised, writable successor to the fixed map ROM: a WIDTH×DEPTH bitmap memory holding the play-field map as one word per row. It provides a registered row-read port for the display scanner, a registered single-bit hit query for collision logic, a write port with word and per-bit set/clear/toggle operations, and a sequenced clear sweep. It sits between game logic (writer) and the video/collision path (readers).

## Interface
- WIDTH, 32, bits per row (≥2)
- DEPTH, 32, number of rows (≥2, need not be a power of 2)
- AW, $clog2(DEPTH), row address width (derived)
- CW, $clog2(WIDTH), column address width (derived)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- rd_addr  in  AW  row to read
- rd_bits  out  WIDTH  registered row contents
- q_row  in  AW  hit-query row
- q_col  in  CW  hit-query column
- q_hit  out  1  registered bit at (q_row, q_col)
- wr_en  in  1  write strobe
- wr_op  in  2  00 word write, 01 set bit, 10 clear bit, 11 toggle bit
- wr_addr  in  AW  row to write
- wr_col  in  CW  bit index for bit ops
- wr_data  in  WIDTH  row word for op 00
- clr_req  in  1  start clear sweep
- busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse when sweep completes

## Operation
- Storage: DEPTH×WIDTH flop array; bit 0 of a row is column 0.
- Reset: every row, rd_bits, q_hit, busy, clr_done, sweep counter → 0; FSM → IDLE. Reset mid-sweep aborts it with no clr_done pulse.
- Writes (IDLE only, wr_en=1): op 00 row←wr_data; op 01/10/11 read-modify-write of bit wr_col, all other bits unchanged, single cycle.
- Out-of-range: wr_addr ≥ DEPTH or wr_col ≥ WIDTH → write ignored; rd_addr/q_row ≥ DEPTH or q_col ≥ WIDTH → 0 returned.
- FSM: IDLE --clr_req--> CLEAR (cnt=0). In CLEAR each cycle zeroes row cnt, cnt++; after row DEPTH-1, clr_done=1 for one cycle and FSM → IDLE.
- In CLEAR: wr_en ignored (dropped, not queued); clr_req ignored; reads stay live and show partially cleared contents.
- clr_req and wr_en in the same IDLE cycle: clear wins, write dropped.

## Timing
- rd_bits and q_hit: 1-cycle latency; read-before-write, so a same-cycle write to the read row is visible on the cycle after next.
- Write takes effect at the sampling edge.
- busy rises on the edge that samples clr_req and stays high for exactly DEPTH cycles. clr_done is asserted in the cycle after the last row is cleared, coincident with busy falling.
- clr_req can be accepted again in the cycle clr_done is high, since the FSM is already IDLE.

## Structure
- Package map_pkg: wr_op encodings (OP_WORD, OP_SET, OP_CLR, OP_TGL) and FSM state enum (ST_IDLE, ST_CLEAR).
- Sub-module map_bit_alu: combinational old_row, wr_op, wr_col, wr_data → new_row. Unit-testable on its own.
- All other logic lives in map_store.

## Test plan
- Reset then read rows 0 and 31 → rd_bits=0, q_hit=0, busy=0.
- Word write row 5 = 32'hDEADBEEF, then rd_addr=5 → 32'hDEADBEEF one cycle later.
- Bit ops on that row: set col 0, clear col 1, toggle col 31 → 32'h5EADBEED; q_row=5, q_col=31 → q_hit=0.
- Same-cycle write 32'h1 to row 3 with rd_addr=3 → old value first, 32'h1 on the following read.
- Fill all rows with 32'hFFFFFFFF, pulse clr_req → busy high for 32 cycles; writes issued during the sweep are dropped; clr_done pulses once; every row reads 0.
- Assert reset at sweep cycle 10 → busy=0 immediately, no clr_done, all rows read 0. With DEPTH=20, write to address 25 → ignored, and reading address 25 returns 0.
